// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: owns the single command port of a synchronous-read byte memory.
// After reset (and on clr_start) it sweeps CLR_VAL into every entry; otherwise it
// grants one access per cycle to requester A or B, range-checks the address and
// returns tagged read data / error pulses one cycle after the grant.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (A always wins on contention).
module mem_port_arbiter #(
    parameter int unsigned   AW      = 4,
    parameter int unsigned   DW      = 8,
    parameter int unsigned   DEPTH   = 10,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_start,
    output logic          busy,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic          a_err,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic          b_err,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StServe} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          a_rvalid_q, a_rvalid_d;
    logic          b_rvalid_q, b_rvalid_d;
    logic          a_err_q, a_err_d;
    logic          b_err_q, b_err_d;
    logic          a_in_range, b_in_range;

    assign a_in_range = 32'(a_addr) < DEPTH;
    assign b_in_range = 32'(b_addr) < DEPTH;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // A has strict priority; B only wins an idle-A cycle.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (state_q == StServe) begin
            a_gnt = a_req;
            b_gnt = b_req && !a_req;
        end
    end
`else
    // last_q: 0 = A won most recently, 1 = B won most recently.
    logic last_q, last_d;

    // Round-robin grant: on contention the requester that did not win last goes.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (state_q == StServe) begin
            a_gnt = a_req && (!b_req || last_q);
            b_gnt = b_req && (!a_req || !last_q);
        end
    end

    // Track the most recent winner.
    always_comb begin
        last_d = last_q;
        if (a_gnt) begin
            last_d = 1'b0;
        end else if (b_gnt) begin
            last_d = 1'b1;
        end
    end

    // Reset favours A on the first contended cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Drive the memory command port: sweep writes in CLEAR, granted in-range access in SERVE.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            unique case (state_q)
                StClear: begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = clr_addr_q;
                    mem_wdata = CLR_VAL;
                end
                StServe: begin
                    if (a_gnt && a_in_range) begin
                        mem_en    = 1'b1;
                        mem_we    = a_we;
                        mem_addr  = a_addr;
                        mem_wdata = a_wdata;
                    end else if (b_gnt && b_in_range) begin
                        mem_en    = 1'b1;
                        mem_we    = b_we;
                        mem_addr  = b_addr;
                        mem_wdata = b_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state, sweep address and the one-cycle-late response flags.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        a_rvalid_d = a_gnt && !a_we && a_in_range;
        b_rvalid_d = b_gnt && !b_we && b_in_range;
        a_err_d    = a_gnt && !a_in_range;
        b_err_d    = b_gnt && !b_in_range;
        unique case (state_q)
            StClear: begin
                clr_addr_d = clr_addr_q + AW'(1);
                if (clr_addr_q == LastAddr) begin
                    state_d    = StServe;
                    clr_addr_d = '0;
                end
            end
            StServe: begin
                // A grant in this cycle still completes; the sweep starts next cycle.
                if (clr_start) begin
                    state_d    = StClear;
                    clr_addr_d = '0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    // State and response registers; reset discards any in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            b_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_err_q    <= a_err_d;
            b_err_q    <= b_err_d;
        end
    end

    assign busy     = (state_q == StClear);
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_err    = a_err_q;
    assign b_err    = b_err_q;
    assign rdata    = (a_rvalid_q || b_rvalid_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural sync-read memory, a directed vector table
// for single-cycle behaviour, and hand-written sequences for sweep / clr_start / reset.
module tb_mem_port_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk, rst, clr_start, busy;
    logic       a_req, a_we, a_gnt, a_rvalid, a_err;
    logic       b_req, b_we, b_gnt, b_rvalid, b_err;
    logic [3:0] a_addr, b_addr, mem_addr;
    logic [7:0] a_wdata, b_wdata, rdata, mem_wdata, mem_rdata;
    logic       mem_en, mem_we;

    logic [7:0] mem [16];

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .clr_start (clr_start),
        .busy      (busy),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_err     (a_err),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_err     (b_err),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read memory model; pre-filled with junk so the sweep is visible.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hA5;
        mem_rdata = 8'h00;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Checks DEPTH-start cycles of a clear sweep beginning at sweep index start.
    task automatic run_sweep(input int start, input logic check_rv);
        for (int i = start; i < 10; i++) begin
            #1;
            chk("sweep_busy", 32'(busy), 32'd1);
            chk("sweep_mem_en", 32'(mem_en), 32'd1);
            chk("sweep_mem_we", 32'(mem_we), 32'd1);
            chk("sweep_mem_addr", 32'(mem_addr), 32'(i));
            chk("sweep_mem_wdata", 32'(mem_wdata), 32'h00);
            chk("sweep_a_gnt", 32'(a_gnt), 32'd0);
            chk("sweep_b_gnt", 32'(b_gnt), 32'd0);
            if (check_rv) begin
                chk("sweep_a_rvalid", 32'(a_rvalid), 32'd0);
                chk("sweep_b_rvalid", 32'(b_rvalid), 32'd0);
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic       clr;
        logic       a_req;
        logic       a_we;
        logic [3:0] a_addr;
        logic [7:0] a_wdata;
        logic       b_req;
        logic       b_we;
        logic [3:0] b_addr;
        logic [7:0] b_wdata;
        logic       e_agnt;
        logic       e_bgnt;
        logic       e_arv;
        logic       e_brv;
        logic       e_aerr;
        logic       e_berr;
        logic [7:0] e_rdata;
        logic       e_en;
        logic       e_busy;
    } vec_t;

    vec_t vecs [15];

    initial begin
        // clr a_req a_we a_addr a_wdata b_req b_we b_addr b_wdata | agnt bgnt arv brv aerr berr rdata en busy
        vecs[0]  = '{L, H, H, 4'd3, 8'h5A, L, L, 4'd0, 8'h00, H, L, L, L, L, L, 8'h00, H, L};
        vecs[1]  = '{L, L, L, 4'd0, 8'h00, H, L, 4'd3, 8'h00, L, H, L, L, L, L, 8'h00, H, L};
        vecs[2]  = '{L, L, L, 4'd0, 8'h00, L, L, 4'd0, 8'h00, L, L, L, H, L, L, 8'h5A, L, L};
`ifdef MEM_ARB_FIXED_PRIO_EN
        vecs[3]  = '{L, H, L, 4'd3, 8'h00, H, L, 4'd1, 8'h00, H, L, L, L, L, L, 8'h00, H, L};
        vecs[4]  = '{L, H, L, 4'd3, 8'h00, H, L, 4'd1, 8'h00, H, L, H, L, L, L, 8'h5A, H, L};
        vecs[5]  = '{L, H, L, 4'd3, 8'h00, H, L, 4'd1, 8'h00, H, L, H, L, L, L, 8'h5A, H, L};
        vecs[6]  = '{L, H, L, 4'd3, 8'h00, H, L, 4'd1, 8'h00, H, L, H, L, L, L, 8'h5A, H, L};
        vecs[7]  = '{L, L, L, 4'd0, 8'h00, L, L, 4'd0, 8'h00, L, L, H, L, L, L, 8'h5A, L, L};
`else
        vecs[3]  = '{L, H, L, 4'd3, 8'h00, H, L, 4'd1, 8'h00, H, L, L, L, L, L, 8'h00, H, L};
        vecs[4]  = '{L, H, L, 4'd3, 8'h00, H, L, 4'd1, 8'h00, L, H, H, L, L, L, 8'h5A, H, L};
        vecs[5]  = '{L, H, L, 4'd3, 8'h00, H, L, 4'd1, 8'h00, H, L, L, H, L, L, 8'h00, H, L};
        vecs[6]  = '{L, H, L, 4'd3, 8'h00, H, L, 4'd1, 8'h00, L, H, H, L, L, L, 8'h5A, H, L};
        vecs[7]  = '{L, L, L, 4'd0, 8'h00, L, L, 4'd0, 8'h00, L, L, L, H, L, L, 8'h00, L, L};
`endif
        vecs[8]  = '{L, H, L, 4'd12, 8'h00, L, L, 4'd0, 8'h00, H, L, L, L, L, L, 8'h00, L, L};
        vecs[9]  = '{L, L, L, 4'd0, 8'h00, L, L, 4'd0, 8'h00, L, L, L, L, H, L, 8'h00, L, L};
        vecs[10] = '{L, L, L, 4'd0, 8'h00, H, H, 4'd15, 8'h33, L, H, L, L, L, L, 8'h00, L, L};
        vecs[11] = '{L, L, L, 4'd0, 8'h00, L, L, 4'd0, 8'h00, L, L, L, L, L, H, 8'h00, L, L};
        vecs[12] = '{L, H, H, 4'd9, 8'hFF, L, L, 4'd0, 8'h00, H, L, L, L, L, L, 8'h00, H, L};
        vecs[13] = '{L, H, L, 4'd9, 8'h00, L, L, 4'd0, 8'h00, H, L, L, L, L, L, 8'h00, H, L};
        vecs[14] = '{L, L, L, 4'd0, 8'h00, L, L, 4'd0, 8'h00, L, L, H, L, L, L, 8'hFF, L, L};

        rst = 1'b1;
        clr_start = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

        // Reset state.
        @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'h00);
        chk("rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
        chk("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
        chk("rst_err", 32'({a_err, b_err}), 32'd0);

        // Initial sweep with both requesters pending: no grant may leak through.
        @(negedge clk);
        rst = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
        run_sweep(0, 1'b1);

        // Single-cycle vectors.
        foreach (vecs[i]) begin
            clr_start = vecs[i].clr;
            a_req = vecs[i].a_req; a_we = vecs[i].a_we;
            a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wdata;
            b_req = vecs[i].b_req; b_we = vecs[i].b_we;
            b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wdata;
            #1;
            chk($sformatf("v%0d_a_gnt", i), 32'(a_gnt), 32'(vecs[i].e_agnt));
            chk($sformatf("v%0d_b_gnt", i), 32'(b_gnt), 32'(vecs[i].e_bgnt));
            chk($sformatf("v%0d_a_rvalid", i), 32'(a_rvalid), 32'(vecs[i].e_arv));
            chk($sformatf("v%0d_b_rvalid", i), 32'(b_rvalid), 32'(vecs[i].e_brv));
            chk($sformatf("v%0d_a_err", i), 32'(a_err), 32'(vecs[i].e_aerr));
            chk($sformatf("v%0d_b_err", i), 32'(b_err), 32'(vecs[i].e_berr));
            chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].e_rdata));
            chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].e_en));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            @(negedge clk);
        end

        // clr_start together with an A read of addr 9 (holds 0xFF): the read completes.
        clr_start = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd9;
        #1;
        chk("clr_req_a_gnt", 32'(a_gnt), 32'd1);
        chk("clr_req_busy", 32'(busy), 32'd0);
        chk("clr_req_mem_addr", 32'(mem_addr), 32'd9);
        chk("clr_req_mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        // First CLEAR cycle: in-flight rvalid still delivered.
        clr_start = 1'b0;
        #1;
        chk("clr0_busy", 32'(busy), 32'd1);
        chk("clr0_a_gnt", 32'(a_gnt), 32'd0);
        chk("clr0_a_rvalid", 32'(a_rvalid), 32'd1);
        chk("clr0_rdata", 32'(rdata), 32'hFF);
        chk("clr0_mem_addr", 32'(mem_addr), 32'd0);
        chk("clr0_mem_we", 32'(mem_we), 32'd1);
        @(negedge clk);
        // clr_start mid-sweep must not restart it.
        clr_start = 1'b1;
        #1;
        chk("clr1_busy", 32'(busy), 32'd1);
        chk("clr1_a_gnt", 32'(a_gnt), 32'd0);
        chk("clr1_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("clr1_mem_addr", 32'(mem_addr), 32'd1);
        @(negedge clk);
        clr_start = 1'b0;
        run_sweep(2, 1'b1);
        // Held A request is granted as soon as the sweep ends; addr 9 now cleared.
        #1;
        chk("post_clr_busy", 32'(busy), 32'd0);
        chk("post_clr_a_gnt", 32'(a_gnt), 32'd1);
        chk("post_clr_mem_addr", 32'(mem_addr), 32'd9);
        @(negedge clk);
        a_req = 1'b0;
        #1;
        chk("post_clr_a_rvalid", 32'(a_rvalid), 32'd1);
        chk("post_clr_rdata", 32'(rdata), 32'h00);
        @(negedge clk);

        // Reset in the cycle after an A read grant.
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
        #1;
        chk("prerst_a_gnt", 32'(a_gnt), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        a_req = 1'b0;
        #1;
        chk("midrst_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("midrst_rdata", 32'(rdata), 32'h00);
        chk("midrst_mem_en", 32'(mem_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_sweep(0, 1'b1);
        #1;
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("final_mem_en", 32'(mem_en), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
